// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Operand-fetch / execute / writeback sequencer wrapped around an external
//   combinational ALU. Owns the 16-entry register file and the 5-bit PSR.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | issue_ready high; accept and latch one decoded instruction
//   FETCH | read operands and carry, load them into the ALU drive regs
//   EXEC  | ALU inputs held steady; capture alu_z / alu_flags at the edge
//   WB    | done pulse; PSR update; register write unless the op is CMP
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   issue_valid / issue_ready  instruction handshake
//   issue_op/rdest/rsrc/imm/use_imm  decoded instruction fields
//   alu_a/alu_b/alu_op/alu_carry     drive to the ALU (non-zero only in EXEC)
//   alu_z, alu_flags           ALU result and flags
//   done                       one-cycle pulse in the writeback cycle
//   psr                        current flags register
//   ld_en/ld_addr/ld_data      host register load
//   dbg_addr/dbg_data          combinational register read-back
module alu_exec_stage #(
  parameter int WORD_WIDTH     = 16,
  parameter int OPCODE_WIDTH   = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CARRY_BIT      = 0,
  parameter logic [OPCODE_WIDTH-1:0] CMP_OPCODE = 8'b0000_1011
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [OPCODE_WIDTH-1:0]   issue_op,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rdest,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rsrc,
  input  logic [WORD_WIDTH-1:0]     issue_imm,
  input  logic                      issue_use_imm,
  output logic [WORD_WIDTH-1:0]     alu_a,
  output logic [WORD_WIDTH-1:0]     alu_b,
  output logic [OPCODE_WIDTH-1:0]   alu_op,
  output logic                      alu_carry,
  input  logic [WORD_WIDTH-1:0]     alu_z,
  input  logic [4:0]                alu_flags,
  output logic                      done,
  output logic [4:0]                psr,
  input  logic                      ld_en,
  input  logic [REG_ADDR_WIDTH-1:0] ld_addr,
  input  logic [WORD_WIDTH-1:0]     ld_data,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [WORD_WIDTH-1:0]     dbg_data
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t state, state_next;

  logic [WORD_WIDTH-1:0]     regs [NUM_REGS];
  logic [OPCODE_WIDTH-1:0]   op_q;
  logic [REG_ADDR_WIDTH-1:0] rdest_q;
  logic [REG_ADDR_WIDTH-1:0] rsrc_q;
  logic [WORD_WIDTH-1:0]     imm_q;
  logic                      use_imm_q;
  logic [WORD_WIDTH-1:0]     result_q;
  logic [4:0]                flg_q;
  logic [WORD_WIDTH-1:0]     fetch_a;
  logic [WORD_WIDTH-1:0]     fetch_b;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue_valid) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    issue_ready = (state == IDLE);
    done        = (state == WB);
  end

  // A host load landing on the same edge that closes FETCH is forwarded, so
  // any load that lands at or before that edge is seen by the instruction.
  always_comb begin
    fetch_a = regs[rdest_q];
    fetch_b = use_imm_q ? imm_q : regs[rsrc_q];
    if (ld_en && (ld_addr == rdest_q)) fetch_a = ld_data;
    if (ld_en && !use_imm_q && (ld_addr == rsrc_q)) fetch_b = ld_data;
  end

  // instruction latch, ALU drive registers, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      result_q  <= '0;
      flg_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            op_q      <= issue_op;
            rdest_q   <= issue_rdest;
            rsrc_q    <= issue_rsrc;
            imm_q     <= issue_imm;
            use_imm_q <= issue_use_imm;
          end
        end
        FETCH: begin
          // loaded here so they are stable for the whole EXEC cycle
          alu_a     <= fetch_a;
          alu_b     <= fetch_b;
          alu_op    <= op_q;
          alu_carry <= psr[CARRY_BIT];
        end
        EXEC: begin
          result_q  <= alu_z;
          flg_q     <= alu_flags;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_op    <= '0;
          alu_carry <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // register file and PSR; the writeback assignment comes last so it wins
  // over a host load to the same register on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      psr <= '0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      if (state == WB) begin
        psr <= flg_q;
        if (op_q != CMP_OPCODE) regs[rdest_q] <= result_q;
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_op;
  logic [3:0]  issue_rdest;
  logic [3:0]  issue_rsrc;
  logic [15:0] issue_imm;
  logic        issue_use_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_op;
  logic        alu_carry;
  logic [15:0] alu_z;
  logic [4:0]  alu_flags;
  logic        done;
  logic [4:0]  psr;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  alu_exec_stage dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_rdest(issue_rdest), .issue_rsrc(issue_rsrc),
    .issue_imm(issue_imm), .issue_use_imm(issue_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry(alu_carry),
    .alu_z(alu_z), .alu_flags(alu_flags),
    .done(done), .psr(psr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic set_issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [15:0] imm, input logic use_imm);
    issue_valid = 1'b1; issue_op = op; issue_rdest = rd; issue_rsrc = rs;
    issue_imm = imm; issue_use_imm = use_imm;
  endtask

  // run a full instruction with the ALU returning z/flags; cycle after accept
  task automatic run_instr(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [15:0] imm, input logic use_imm,
                           input logic [15:0] z, input logic [4:0] f);
    alu_z = z; alu_flags = f;
    set_issue(op, rd, rs, imm, use_imm);
    tick();            // accept
    issue_valid = 1'b0;
    tick();            // EXEC
    tick();            // WB
    tick();            // IDLE
  endtask

  int d0;

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rdest = '0; issue_rsrc = '0;
    issue_imm = '0; issue_use_imm = 1'b0; alu_z = '0; alu_flags = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    tick(); tick();
    reset = 1'b0;
    d0 = done_cnt;

    // reset / idle
    check("rst_psr", {27'h0, psr}, 32'h0);
    check("rst_ready", {31'h0, issue_ready}, 32'h1);
    check("rst_alu_a", {16'h0, alu_a}, 32'h0);
    for (int i = 0; i < 16; i++) reg_check("rst_reg", 4'(i), 16'h0);
    tick(); tick();
    check("idle_no_done", done_cnt - d0, 0);

    // basic add: r1 = 5, r2 = 7
    load(4'd1, 16'h0005);
    load(4'd2, 16'h0007);
    alu_z = 16'h000C; alu_flags = 5'b00010;
    set_issue(8'h05, 4'd1, 4'd2, 16'hDEAD, 1'b0);
    d0 = done_cnt;
    tick();                       // accept edge -> FETCH
    issue_valid = 1'b0;
    check("fetch_ready", {31'h0, issue_ready}, 32'h0);
    check("fetch_done", {31'h0, done}, 32'h0);
    check("fetch_alu_a", {16'h0, alu_a}, 32'h0);
    tick();                       // EXEC
    check("exec_alu_a", {16'h0, alu_a}, 32'h0005);
    check("exec_alu_b", {16'h0, alu_b}, 32'h0007);
    check("exec_alu_op", {24'h0, alu_op}, 32'h05);
    check("exec_carry", {31'h0, alu_carry}, 32'h0);
    check("exec_done", {31'h0, done}, 32'h0);
    tick();                       // WB: third cycle after the accept edge
    check("wb_done", {31'h0, done}, 32'h1);
    check("wb_alu_a", {16'h0, alu_a}, 32'h0);
    tick();                       // IDLE
    check("add_done_cnt", done_cnt - d0, 1);
    check("add_ready", {31'h0, issue_ready}, 32'h1);
    reg_check("add_r1", 4'd1, 16'h000C);
    check("add_psr", {27'h0, psr}, 32'h02);

    // CMP: psr only
    run_instr(8'h0B, 4'd1, 4'd2, 16'h0, 1'b0, 16'hFFFE, 5'b10000);
    reg_check("cmp_r1", 4'd1, 16'h000C);
    check("cmp_psr", {27'h0, psr}, 32'h10);

    // carry in and immediate operand
    run_instr(8'h05, 4'd3, 4'd2, 16'h0, 1'b0, 16'h0001, 5'b00001);
    check("c_psr", {27'h0, psr}, 32'h01);
    load(4'd4, 16'hBEEF);
    alu_z = 16'h5555; alu_flags = 5'b00000;
    set_issue(8'h06, 4'd3, 4'd4, 16'h1234, 1'b1);
    tick();
    issue_valid = 1'b0;
    tick();                       // EXEC
    check("imm_carry", {31'h0, alu_carry}, 32'h1);
    check("imm_alu_b", {16'h0, alu_b}, 32'h1234);
    check("imm_alu_a", {16'h0, alu_a}, 32'h0001);
    check("imm_alu_op", {24'h0, alu_op}, 32'h06);
    tick(); tick();
    reg_check("imm_r3", 4'd3, 16'h5555);
    reg_check("imm_r4", 4'd4, 16'hBEEF);
    check("imm_psr", {27'h0, psr}, 32'h00);

    // issue_valid toggling while busy; host load colliding with WB
    alu_z = 16'hAAAA; alu_flags = 5'b00100;
    set_issue(8'h01, 4'd5, 4'd2, 16'h0, 1'b0);
    d0 = done_cnt;
    tick();                       // accept -> FETCH
    issue_rdest = 4'd6; issue_valid = 1'b0;
    tick();                       // EXEC
    issue_valid = 1'b1;
    check("busy_ready", {31'h0, issue_ready}, 32'h0);
    tick();                       // WB
    issue_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 4'd5; ld_data = 16'h1111;
    tick();                       // IDLE
    ld_en = 1'b0;
    tick(); tick(); tick();
    check("busy_done_cnt", done_cnt - d0, 1);
    reg_check("wb_wins_r5", 4'd5, 16'hAAAA);
    reg_check("no_2nd_r6", 4'd6, 16'h0000);
    check("busy_psr", {27'h0, psr}, 32'h04);
    check("busy_idle", {31'h0, issue_ready}, 32'h1);

    // reset during EXEC aborts the instruction
    load(4'd7, 16'h0077);
    alu_z = 16'h9999; alu_flags = 5'b11111;
    set_issue(8'h05, 4'd7, 4'd2, 16'h0, 1'b0);
    d0 = done_cnt;
    tick();                       // FETCH
    issue_valid = 1'b0;
    tick();                       // EXEC
    check("pre_rst_alu_a", {16'h0, alu_a}, 32'h0077);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", {31'h0, issue_ready}, 32'h1);
    check("abort_psr", {27'h0, psr}, 32'h0);
    check("abort_alu_a", {16'h0, alu_a}, 32'h0);
    reg_check("abort_r7", 4'd7, 16'h0000);
    tick(); tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_psr_late", {27'h0, psr}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
